// File: rtl/imem_debug_loader.sv
// Debug-side program loader: assembles UART bytes into 32-bit words, writes them
// into instruction memory, then sequences the PC stall for run and single-step.
module imem_debug_loader #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] END_WORD = 32'hFFFF_FFFF,
  parameter logic [7:0]  CMD_LOAD = 8'h4C,
  parameter logic [7:0]  CMD_RUN  = 8'h43,
  parameter logic [7:0]  CMD_STEP = 8'h53
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              cpu_halt,
  output logic [31:0]       data_instruction,
  output logic              wr_instruction,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              stopPC_debug,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              step_done,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        debugState
);

  // IDLE is encoded as 0 so a zero on debugState always means "waiting for a command".
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    RUN   = 3'd3,
    STEP  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t      state;
  logic [1:0]  byteIdx;
  logic [23:0] asmReg;
  logic        byteFire;

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready; rx_ready is
  // registered and never depends on rx_valid, and the sender holds rx_data stable
  // while rx_valid is high and the byte has not yet transferred.
  assign byteFire   = rx_valid && rx_ready;
  assign debugState = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      byteIdx          <= '0;
      asmReg           <= '0;
      rx_ready         <= 1'b1;
      wr_instruction   <= 1'b0;
      wr_addr          <= '0;
      data_instruction <= '0;
      stopPC_debug     <= 1'b1;
      cpu_rst          <= 1'b0;
      load_done        <= 1'b0;
      step_done        <= 1'b0;
      word_count       <= '0;
    end else begin
      wr_instruction <= 1'b0;
      load_done      <= 1'b0;
      step_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (byteFire) begin
            if (rx_data == CMD_LOAD) begin
              state      <= LOAD;
              word_count <= '0;
              wr_addr    <= '0;
              byteIdx    <= '0;
              asmReg     <= '0;
              cpu_rst    <= 1'b1;
            end else if (rx_data == CMD_RUN) begin
              state        <= RUN;
              stopPC_debug <= 1'b0;
              rx_ready     <= 1'b0;
            end else if (rx_data == CMD_STEP) begin
              state        <= STEP;
              // A CPU already halted on entry gets no enable cycle.
              stopPC_debug <= cpu_halt;
              rx_ready     <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (byteFire) begin
            if (byteIdx == 2'd3) begin
              state            <= WRITE;
              rx_ready         <= 1'b0;
              wr_instruction   <= 1'b1;
              data_instruction <= {asmReg, rx_data};
              byteIdx          <= '0;
            end else begin
              asmReg  <= {asmReg[15:0], rx_data};
              byteIdx <= byteIdx + 2'd1;
            end
          end
        end
        WRITE: begin
          word_count <= word_count + 1'b1;
          asmReg     <= '0;
          rx_ready   <= 1'b1;
          if (wr_addr != LAST_ADDR) begin
            wr_addr <= wr_addr + 1'b1;
          end
          if (data_instruction == END_WORD || wr_addr == LAST_ADDR) begin
            state     <= IDLE;
            load_done <= 1'b1;
            cpu_rst   <= 1'b0;
          end else begin
            state <= LOAD;
          end
        end
        RUN: begin
          if (cpu_halt) begin
            state        <= IDLE;
            stopPC_debug <= 1'b1;
            rx_ready     <= 1'b1;
          end
        end
        STEP: begin
          state        <= IDLE;
          stopPC_debug <= 1'b1;
          step_done    <= 1'b1;
          rx_ready     <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          stopPC_debug <= 1'b1;
          rx_ready     <= 1'b1;
          cpu_rst      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_debug_loader.sv
// Bench for imem_debug_loader: reset, table-driven word assembly, directed run/step
// sequences, randomized gapped loads and a small-memory boundary instance.
module tb_imem_debug_loader;

  localparam int AW  = 10;
  localparam int AW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cpu_halt = 1'b0;
  logic       sel = 1'b0;
  logic       rx_valid_a, rx_valid_b, rdy;

  logic           rdy_a, wr_a, stop_a, crst_a, ldone_a, sdone_a;
  logic [31:0]    data_a;
  logic [AW-1:0]  addr_a;
  logic [AW:0]    wcnt_a;
  logic [2:0]     dbg_a;
  logic           rdy_b, wr_b, stop_b, crst_b, ldone_b, sdone_b;
  logic [31:0]    data_b;
  logic [AW2-1:0] addr_b;
  logic [AW2:0]   wcnt_b;
  logic [2:0]     dbg_b;

  assign rx_valid_a = rx_valid && !sel;
  assign rx_valid_b = rx_valid && sel;
  assign rdy        = sel ? rdy_b : rdy_a;

  imem_debug_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_a), .rx_ready(rdy_a),
    .cpu_halt(cpu_halt), .data_instruction(data_a), .wr_instruction(wr_a),
    .wr_addr(addr_a), .stopPC_debug(stop_a), .cpu_rst(crst_a), .load_done(ldone_a),
    .step_done(sdone_a), .word_count(wcnt_a), .debugState(dbg_a)
  );

  imem_debug_loader #(.ADDR_W(AW2)) dut_small (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_b), .rx_ready(rdy_b),
    .cpu_halt(cpu_halt), .data_instruction(data_b), .wr_instruction(wr_b),
    .wr_addr(addr_b), .stopPC_debug(stop_b), .cpu_rst(crst_b), .load_done(ldone_b),
    .step_done(sdone_b), .word_count(wcnt_b), .debugState(dbg_b)
  );

  int checks = 0;
  int fails  = 0;
  int ld_cnt_a = 0, ld_cnt_b = 0, sd_cnt_a = 0, stop_low_a = 0;

  logic [63:0] exp_q_a[$];
  logic [63:0] exp_q_b[$];
  logic [63:0] e_a, e_b;
  logic [31:0] prog[$];
  logic [7:0]  bytes_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboards: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (ldone_a === 1'b1) ld_cnt_a++;
      if (ldone_b === 1'b1) ld_cnt_b++;
      if (sdone_a === 1'b1) sd_cnt_a++;
      if (stop_a === 1'b0) stop_low_a++;
      if (wr_a === 1'b1) begin
        checks++;
        if (exp_q_a.size() == 0) begin
          fails++;
          $display("FAIL strobe_a: unexpected addr %0h data %0h, required no strobe", addr_a, data_a);
        end else begin
          e_a = exp_q_a.pop_front();
          if ({32'(addr_a), data_a} !== e_a || crst_a !== 1'b1) begin
            fails++;
            $display("FAIL strobe_a: got addr %0h data %0h cpu_rst %0b, required addr %0h data %0h cpu_rst 1",
                     addr_a, data_a, crst_a, e_a[63:32], e_a[31:0]);
          end
        end
      end
      if (wr_b === 1'b1) begin
        checks++;
        if (exp_q_b.size() == 0) begin
          fails++;
          $display("FAIL strobe_b: unexpected addr %0h data %0h, required no strobe", addr_b, data_b);
        end else begin
          e_b = exp_q_b.pop_front();
          if ({32'(addr_b), data_b} !== e_b) begin
            fails++;
            $display("FAIL strobe_b: got addr %0h data %0h, required addr %0h data %0h",
                     addr_b, data_b, e_b[63:32], e_b[31:0]);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rdy && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      fails++;
      $display("FAIL rx_ready_timeout: ready 0 after %0d cycles, required 1", n);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_load(input int max_gap);
    send_byte(8'h4C);
    foreach (bytes_q[i]) begin
      send_byte(bytes_q[i]);
      if (max_gap > 0 && i != bytes_q.size() - 1) idle($urandom_range(max_gap, 0));
    end
  endtask

  // Reference: words go to consecutive addresses from 0, stopping after the end
  // marker (which is written) or once the memory is full.
  task automatic model_load(input int depth, output int n_words);
    logic [31:0] w;
    n_words = 0;
    bytes_q.delete();
    foreach (prog[i]) begin
      w = prog[i];
      for (int k = 0; k < 4; k++) bytes_q.push_back(8'((w >> (24 - 8 * k)) & 32'hFF));
      if (n_words < depth) begin
        if (sel) exp_q_b.push_back({32'(n_words), w});
        else     exp_q_a.push_back({32'(n_words), w});
        n_words++;
        if (w == 32'hFFFF_FFFF) break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] word;
    int          nstrobe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ld0, sd0, low0, low;
    logic [7:0] j;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'h0000_0001, 2};
    vecs[1] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h1234_5678, 2};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 1};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 32'hFFFF_FFFE, 2};
    vecs[4] = '{8'h4C, 8'h43, 8'h53, 8'h00, 32'h4C43_5300, 2};

    // Reset held with a command byte offered
    rst = 1'b0; rx_valid = 1'b1; rx_data = 8'h4C;
    @(posedge clk); @(posedge clk); #1;
    check("rst_rx_ready", rdy_a, 1);
    check("rst_wr", wr_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_data", data_a, 0);
    check("rst_stop", stop_a, 1);
    check("rst_cpu_rst", crst_a, 0);
    check("rst_load_done", ldone_a, 0);
    check("rst_step_done", sdone_a, 0);
    check("rst_word_count", wcnt_a, 0);
    check("rst_state", dbg_a, 0);
    check("rst_small_ready", rdy_b, 1);
    rx_valid = 1'b0; rst = 1'b1;
    idle(2);
    check("rst_no_consume_cpu_rst", crst_a, 0);
    check("rst_no_consume_state", dbg_a, 0);

    // Directed load with latency and completion checks
    prog = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF};
    ld0 = ld_cnt_a;
    model_load(1 << AW, n);
    send_byte(8'h4C);
    check("load_cpu_rst_high", crst_a, 1);
    foreach (bytes_q[i]) send_byte(bytes_q[i]);
    check("load_strobe_latency", wr_a, 1);
    idle(1);
    check("load_done_pulse", ldone_a, 1);
    check("load_cpu_rst_low", crst_a, 0);
    check("load_word_count", wcnt_a, 3);
    check("load_ready_after", rdy_a, 1);
    idle(1);
    check("load_done_single", ldone_a, 0);
    check("load_done_count", ld_cnt_a - ld0, 1);
    check("load_queue_drained", exp_q_a.size(), 0);

    // Table-driven word assembly
    for (int v = 0; v < 5; v++) begin
      ld0 = ld_cnt_a;
      bytes_q = '{vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3};
      exp_q_a.push_back({32'd0, vecs[v].word});
      if (vecs[v].nstrobe == 2) begin
        bytes_q.push_back(8'hFF); bytes_q.push_back(8'hFF);
        bytes_q.push_back(8'hFF); bytes_q.push_back(8'hFF);
        exp_q_a.push_back({32'd1, 32'hFFFF_FFFF});
      end
      send_load(0);
      idle(2);
      check("vec_word_count", wcnt_a, 64'(vecs[v].nstrobe));
      check("vec_queue_drained", exp_q_a.size(), 0);
      check("vec_load_done", ld_cnt_a - ld0, 1);
    end

    // Gapped bytes give the same strobe sequence
    prog = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF};
    model_load(1 << AW, n);
    send_load(5);
    idle(3);
    check("gap_queue_drained", exp_q_a.size(), 0);
    check("gap_word_count", wcnt_a, 3);

    // Run: 20 cycles free-running, then halt; a step command offered meanwhile is refused
    sd0 = sd_cnt_a;
    send_byte(8'h43);
    check("run_entry_stop", stop_a, 0);
    check("run_entry_ready", rdy_a, 0);
    rx_valid = 1'b1; rx_data = 8'h53;
    low = 0;
    for (int c = 0; c < 20; c++) begin
      if (stop_a == 1'b0) low++;
      idle(1);
    end
    rx_valid = 1'b0;
    check("run_low_cycles", low, 20);
    cpu_halt = 1'b1;
    check("run_halt_same_cycle", stop_a, 0);
    idle(1);
    check("run_halt_stop", stop_a, 1);
    check("run_halt_ready", rdy_a, 1);
    check("run_halt_state", dbg_a, 0);
    check("run_no_step", sd_cnt_a - sd0, 0);
    cpu_halt = 1'b0;

    // Single steps
    sd0 = sd_cnt_a; low0 = stop_low_a;
    for (int s = 0; s < 3; s++) begin
      send_byte(8'h53);
      check("step_window", stop_a, 0);
      idle(1);
      check("step_refrozen", stop_a, 1);
      check("step_done_pulse", sdone_a, 1);
      idle(1);
      check("step_done_single", sdone_a, 0);
    end
    check("step_low_total", stop_low_a - low0, 3);
    cpu_halt = 1'b1;
    send_byte(8'h53);
    check("step_halt_no_window", stop_a, 1);
    idle(1);
    check("step_halt_done", sdone_a, 1);
    idle(1);
    cpu_halt = 1'b0;
    check("step_done_total", sd_cnt_a - sd0, 4);
    check("step_low_total_halt", stop_low_a - low0, 3);

    // Mid-load reset aborts the load; the next load restarts at address 0
    send_byte(8'h4C); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    check("midrst_state", dbg_a, 0);
    check("midrst_cpu_rst", crst_a, 0);
    check("midrst_ready", rdy_a, 1);
    prog = '{32'h3344_5566, 32'hFFFF_FFFF};
    model_load(1 << AW, n);
    send_load(0);
    idle(2);
    check("midrst_queue_drained", exp_q_a.size(), 0);
    check("midrst_word_count", wcnt_a, 2);

    // Randomized loads, preceded by junk bytes that must be ignored
    for (int r = 0; r < 8; r++) begin
      ld0 = ld_cnt_a;
      repeat ($urandom_range(2, 0)) begin
        j = 8'($urandom_range(255, 0));
        while (j == 8'h4C || j == 8'h43 || j == 8'h53) j = 8'($urandom_range(255, 0));
        send_byte(j);
      end
      prog.delete();
      repeat ($urandom_range(6, 1)) begin
        prog.push_back($urandom);
        if (prog[prog.size() - 1] == 32'hFFFF_FFFF) prog[prog.size() - 1] = 32'h0;
      end
      prog.push_back(32'hFFFF_FFFF);
      model_load(1 << AW, n);
      send_load(5);
      idle(3);
      check("rand_word_count", wcnt_a, 64'(n));
      check("rand_queue_drained", exp_q_a.size(), 0);
      check("rand_load_done", ld_cnt_a - ld0, 1);
    end

    // Boundary: 4-word memory fills without an end marker
    sel = 1'b1;
    ld0 = ld_cnt_b;
    prog = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    model_load(1 << AW2, n);
    send_load(2);
    check("full_last_strobe", wr_b, 1);
    idle(1);
    check("full_load_done", ldone_b, 1);
    check("full_word_count", wcnt_b, 4);
    check("full_addr_hold", addr_b, 3);
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (bytes_q[i]) send_byte(bytes_q[i]);
    idle(3);
    check("full_extra_state", dbg_b, 0);
    check("full_extra_cpu_rst", crst_b, 0);
    check("full_extra_count", wcnt_b, 4);
    check("full_load_done_count", ld_cnt_b - ld0, 1);
    check("full_queue_drained", exp_q_b.size(), 0);
    sel = 1'b0;

    idle(2);
    check("final_queue_a", exp_q_a.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
